// File: rtl/nios_sysid_pkg.sv
// Package for the extended system-ID slave.
// Holds the word map, CONTROL bit positions, CAPS field offsets, the read
// pipeline beat type, and the byte-lane merge shared by SCRATCH and CONTROL.
package nios_sysid_pkg;

  // Word addresses
  localparam int unsigned ADDR_ID        = 32'd0;
  localparam int unsigned ADDR_TS        = 32'd1;
  localparam int unsigned ADDR_SCRATCH   = 32'd2;
  localparam int unsigned ADDR_UP_LO     = 32'd3;
  localparam int unsigned ADDR_UP_HI     = 32'd4;
  localparam int unsigned ADDR_CTRL      = 32'd5;
  localparam int unsigned ADDR_CAPS      = 32'd6;
  localparam int unsigned ADDR_INFO_BASE = 32'd7;

  // CONTROL bit indices
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;

  // CAPS field offsets
  localparam int CAPS_NUM_INFO_LSB = 0;
  localparam int CAPS_ADDR_W_LSB   = 8;
  localparam int CAPS_RD_LAT_LSB   = 16;

  // One read response travelling down the latency pipeline
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_beat_t;

  // Replace the byte lanes selected by be with the matching lanes of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/nios_system_sysid_ext_read_pipe.sv
// sysid_read_pipe: fixed-latency delay line for read responses.
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   in_beat        : {valid, data} produced in the accept cycle
//   out_beat       : the same beat LATENCY cycles later
module sysid_read_pipe
  import nios_sysid_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic     clock,
  input  logic     reset_n,
  input  rd_beat_t in_beat,
  output rd_beat_t out_beat
);

  rd_beat_t stage_q [LATENCY];
  rd_beat_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = in_beat;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: the data lanes are cleared along with the valid bits so readdata
  // sits at 0 during reset and an in-flight read leaves nothing behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_beat = stage_q[LATENCY-1];

endmodule

// File: rtl/nios_system_sysid_ext.sv
// nios_system_sysid_ext: Avalon-MM system-identification slave.
// Returns ID, build timestamp and build-info words, plus a 64-bit uptime
// counter with coherent hi/lo snapshot, a scratch register, a control
// register (EN, CLR pulse) and a configurable read latency.
// Ports:
//   clock, reset_n        : clock, asynchronous active-low reset
//   address               : word address
//   read / write          : single-cycle accepted requests (no waitrequest)
//   byteenable, writedata : write lanes and data
//   readdata, readdatavalid : read response, READ_LATENCY cycles after accept
module nios_system_sysid_ext
  import nios_sysid_pkg::*;
#(
  parameter logic [31:0] ID           = 32'h00000000,
  parameter logic [31:0] TIMESTAMP    = 32'd1650897749,
  parameter int          ADDR_W       = 4,
  parameter int          NUM_INFO     = 4,
  parameter logic [((NUM_INFO > 0) ? 32*NUM_INFO : 32)-1:0] INFO_INIT = '0,
  parameter int          READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [3:0]        byteenable,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] CAPS_VALUE =
    (32'(8'(READ_LATENCY)) << CAPS_RD_LAT_LSB) |
    (32'(8'(ADDR_W))       << CAPS_ADDR_W_LSB) |
    (32'(8'(NUM_INFO))     << CAPS_NUM_INFO_LSB);

  logic [63:0] uptime_q,  uptime_d;
  logic [31:0] snap_hi_q, snap_hi_d;
  logic [31:0] scratch_q, scratch_d;
  logic        ctrl_en_q, ctrl_en_d;

  logic [31:0] addr_w;
  logic [31:0] ctrl_rd;
  logic [1:0]  ctrl_wr;
  logic        clr;
  logic [31:0] rd_data;
  rd_beat_t    rd_in;
  rd_beat_t    rd_out;

  assign addr_w = 32'(address);

  always_comb begin
    ctrl_rd          = '0;
    ctrl_rd[CTRL_EN] = ctrl_en_q;
  end

  // Read mux: always sees the pre-write register values, so a read and a
  // write to the same word in one cycle returns the old contents.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves it unassigned and no latch is inferred.
    rd_data = '0;
    case (addr_w)
      ADDR_ID:      rd_data = ID;
      ADDR_TS:      rd_data = TIMESTAMP;
      ADDR_SCRATCH: rd_data = scratch_q;
      ADDR_UP_LO:   rd_data = uptime_q[31:0];
      ADDR_UP_HI:   rd_data = snap_hi_q;
      ADDR_CTRL:    rd_data = ctrl_rd;
      ADDR_CAPS:    rd_data = CAPS_VALUE;
      default: begin
        for (int k = 0; k < NUM_INFO; k++) begin
          if (addr_w == ADDR_INFO_BASE + 32'(k)) rd_data = INFO_INIT[32*k +: 32];
        end
      end
    endcase
  end

  always_comb begin
    scratch_d = scratch_q;
    ctrl_en_d = ctrl_en_q;
    snap_hi_d = snap_hi_q;
    clr       = 1'b0;
    // CLR reads back 0, so the merged CLR bit is set only by a lane-0 write.
    ctrl_wr   = 2'(byte_merge(ctrl_rd, writedata, byteenable));

    if (write) begin
      case (addr_w)
        ADDR_SCRATCH: scratch_d = byte_merge(scratch_q, writedata, byteenable);
        ADDR_CTRL: begin
          ctrl_en_d = ctrl_wr[CTRL_EN];
          clr       = ctrl_wr[CTRL_CLR];
        end
        default: ;
      endcase
    end

    // The high half is frozen at the same sample the low-half read returns.
    if (read && addr_w == ADDR_UP_LO) snap_hi_d = uptime_q[63:32];

    if (clr)            uptime_d = '0;
    else if (ctrl_en_q) uptime_d = uptime_q + 64'd1;
    else                uptime_d = uptime_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q  <= '0;
      snap_hi_q <= '0;
      scratch_q <= '0;
      ctrl_en_q <= 1'b1;
    end else begin
      uptime_q  <= uptime_d;
      snap_hi_q <= snap_hi_d;
      scratch_q <= scratch_d;
      ctrl_en_q <= ctrl_en_d;
    end
  end

  // Idle cycles inject zero data so readdata stays 0 between responses.
  always_comb begin
    rd_in.valid = read;
    rd_in.data  = read ? rd_data : '0;
  end

  sysid_read_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_read_pipe (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_beat  (rd_in),
    .out_beat (rd_out)
  );

  assign readdata      = rd_out.data;
  assign readdatavalid = rd_out.valid;

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed bench for nios_system_sysid_ext: one instance at READ_LATENCY 1
// with default identity values, one at READ_LATENCY 3 with custom ID/INFO.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_nios_system_sysid_ext;

  localparam logic [127:0] INFO3 = {32'h4444_0003, 32'h3333_0002,
                                    32'h2222_0001, 32'h1111_0000};
  localparam logic [31:0]  ID3   = 32'hA5A5_1234;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic [31:0] rdata1, rdata3;
  logic        rvalid1, rvalid3;

  int total = 0;
  int bad   = 0;

  nios_system_sysid_ext #(
    .READ_LATENCY (1)
  ) dut1 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (rdata1),
    .readdatavalid (rvalid1)
  );

  nios_system_sysid_ext #(
    .ID           (ID3),
    .INFO_INIT    (INFO3),
    .READ_LATENCY (3)
  ) dut3 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (rdata3),
    .readdatavalid (rvalid3)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single read on the latency-1 instance: response on the next falling
  // edge, strobe gone one cycle later.
  task automatic rd1(input logic [3:0] a, input logic [31:0] exp, input string tag);
    address = a;
    read    = 1'b1;
    @(negedge clock);
    read    = 1'b0;
    check({tag, "_valid"}, 32'(rvalid1), 32'd1);
    check({tag, "_data"},  rdata1,       exp);
    @(negedge clock);
    check({tag, "_idle"},  32'(rvalid1), 32'd0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write      = 1'b0;
    byteenable = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rl3_addr [4];
    logic [31:0] rl3_exp  [4];
    rl3_addr = '{4'd7, 4'd8, 4'd15, 4'd0};
    rl3_exp  = '{32'h1111_0000, 32'h2222_0001, 32'h0000_0000, ID3};

    reset_n    = 1'b0;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    #1;
    check("rst_valid1", 32'(rvalid1), 32'd0);
    check("rst_data1",  rdata1,       32'd0);
    check("rst_valid3", 32'(rvalid3), 32'd0);
    check("rst_data3",  rdata3,       32'd0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    // Identity words with default parameters
    rd1(4'd0, 32'h0000_0000, "id");
    rd1(4'd1, 32'd1650897749, "timestamp");   // 0x6266B355
    rd1(4'd6, 32'h0001_0404, "caps");
    rd1(4'd2, 32'h0000_0000, "scratch_rst");
    rd1(4'd5, 32'h0000_0001, "ctrl_rst");

    // Scratch byte lanes
    wr(4'd2, 32'hDEAD_BEEF, 4'b0101);
    rd1(4'd2, 32'h00AD_00EF, "scratch_be");
    wr(4'd2, 32'hFFFF_FFFF, 4'b0000);
    rd1(4'd2, 32'h00AD_00EF, "scratch_be0");

    // Read and write of the same word in one cycle: read sees old value
    address    = 4'd2;
    writedata  = 32'h1234_5678;
    byteenable = 4'b1111;
    read       = 1'b1;
    write      = 1'b1;
    @(negedge clock);
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'b0000;
    check("rw_valid", 32'(rvalid1), 32'd1);
    check("rw_old",   rdata1,       32'h00AD_00EF);
    @(negedge clock);
    rd1(4'd2, 32'h1234_5678, "rw_new");

    // Unmapped word ignores writes and reads zero
    wr(4'd15, 32'hFFFF_FFFF, 4'b1111);
    rd1(4'd15, 32'h0000_0000, "unmapped");

    // Snapshot across the 32-bit carry: counter preloaded just below it
    address = 4'd3;
    read    = 1'b1;
    force dut1.uptime_q = 64'h0000_0001_FFFF_FFFF;
    @(negedge clock);
    read    = 1'b0;
    release dut1.uptime_q;
    check("snap_lo_valid", 32'(rvalid1), 32'd1);
    check("snap_lo",       rdata1,       32'hFFFF_FFFF);
    @(negedge clock);
    @(negedge clock);
    rd1(4'd4, 32'h0000_0001, "snap_hi");

    // CLR with EN=0: counter cleared and frozen
    wr(4'd5, 32'h0000_0002, 4'b1111);
    rd1(4'd5, 32'h0000_0000, "ctrl_off");
    repeat (10) @(negedge clock);
    rd1(4'd3, 32'h0000_0000, "frozen_a");
    rd1(4'd3, 32'h0000_0000, "frozen_b");

    // CLR with EN=1: restarts from 0, read accepted 5 cycles after the write
    wr(4'd5, 32'h0000_0003, 4'b1111);
    repeat (4) @(negedge clock);
    rd1(4'd3, 32'h0000_0004, "restart");

    // CLR wins over the increment while counting
    wr(4'd5, 32'h0000_0003, 4'b1111);
    rd1(4'd3, 32'h0000_0000, "clr_prio");

    // Latency-3 instance: four back-to-back reads
    repeat (4) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        address = rl3_addr[k];
        read    = 1'b1;
      end else begin
        read    = 1'b0;
      end
      if (k >= 3 && k <= 6) begin
        check($sformatf("rl3_valid%0d", k), 32'(rvalid3), 32'd1);
        check($sformatf("rl3_data%0d", k),  rdata3,       rl3_exp[k-3]);
      end else begin
        check($sformatf("rl3_idle%0d", k),  32'(rvalid3), 32'd0);
      end
      @(negedge clock);
    end

    // Reset one cycle after an accepted read on the latency-3 instance
    address = 4'd1;
    read    = 1'b1;
    @(negedge clock);
    read    = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rstmid_valid3", 32'(rvalid3), 32'd0);
    check("rstmid_data3",  rdata3,       32'd0);
    check("rstmid_valid1", 32'(rvalid1), 32'd0);
    check("rstmid_data1",  rdata1,       32'd0);
    @(negedge clock);
    check("rstlow_valid3", 32'(rvalid3), 32'd0);
    check("rstlow_data3",  rdata3,       32'd0);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("drop_valid%0d", k), 32'(rvalid3), 32'd0);
    end

    rd1(4'd2, 32'h0000_0000, "scratch_after_rst");
    rd1(4'd5, 32'h0000_0001, "ctrl_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
